// File: rtl/fetch_redirect_controller_pkg.sv
// Shared machine configuration and the fetch-unit redirect types used by the
// redirect controller, its priority selector and its bus interface.
package MicroArchConf;
    localparam int PC_WIDTH = 32;
    typedef logic [PC_WIDTH-1:0] PC_Path;
endpackage

package FetchUnitTypes;
    import MicroArchConf::*;

    // Lower code = higher priority.
    typedef enum logic [1:0] {
        REDIR_CMT  = 2'd0,
        REDIR_REN  = 2'd1,
        REDIR_INTR = 2'd2,
        REDIR_PRED = 2'd3
    } RedirectSource;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DELAY  = 2'd1,
        BUBBLE = 2'd2
    } FetchRedirPhase;

    typedef struct packed {
        logic          valid;
        PC_Path        pc;
        RedirectSource src;
    } RedirectEntry;

    localparam RedirectEntry REDIR_NONE = '{valid: 1'b0, pc: '0, src: REDIR_CMT};

    // A candidate displaces a held entry only when strictly older in priority,
    // except that a commit redirect always wins an equal-priority tie.
    function automatic logic outranks(RedirectEntry cand, RedirectEntry held);
        return cand.valid && (!held.valid || (cand.src < held.src) || (cand.src == REDIR_CMT));
    endfunction
endpackage

// File: rtl/fetch_redirect_controller_if.sv
// Redirect request/response bundle between the recovery sources and the
// next-PC stage.
interface fetch_redirect_controller_if;
    import MicroArchConf::*;

    logic        cmtRedirValid;
    PC_Path      cmtRedirPC;
    logic        renRedirValid;
    PC_Path      renRedirPC;
    logic        intrValid;
    PC_Path      intrPC;
    logic        predRedirValid;
    PC_Path      predRedirPC;
    logic        mispredDetect;
    logic        stall;
    logic        redirValid;
    PC_Path      redirPC;
    logic [1:0]  redirSrc;
    logic        sendBubble;
    logic [15:0] bubbleCycles;

    modport master (
        output cmtRedirValid, cmtRedirPC, renRedirValid, renRedirPC,
               intrValid, intrPC, predRedirValid, predRedirPC,
               mispredDetect, stall,
        input  redirValid, redirPC, redirSrc, sendBubble, bubbleCycles
    );

    modport slave (
        input  cmtRedirValid, cmtRedirPC, renRedirValid, renRedirPC,
               intrValid, intrPC, predRedirValid, predRedirPC,
               mispredDetect, stall,
        output redirValid, redirPC, redirSrc, sendBubble, bubbleCycles
    );
endinterface

// File: rtl/fetch_redirect_controller_priority_select.sv
// Picks the winning redirect among the four live requests and the held
// pending entry; the same result feeds both the output and the capture path.
module redirect_priority_select
    import MicroArchConf::*;
    import FetchUnitTypes::*;
(
    input  logic [3:0]   reqValid,   // bit index equals the RedirectSource code
    input  PC_Path       reqPC [4],
    input  RedirectEntry pending,
    output RedirectEntry winner
);
    RedirectEntry best;

    // NOTE: combinational logic uses blocking '=' and assigns every output a
    // default before any branch, so no latch can be inferred.
    always_comb begin
        best = REDIR_NONE;
        // Scan from lowest priority upward so the highest-priority hit is written last.
        for (int i = 3; i >= 0; i--) begin
            if (reqValid[i]) begin
                best = '{valid: 1'b1, pc: reqPC[i], src: RedirectSource'(2'(i))};
            end
        end
        winner = outranks(best, pending) ? best : pending;
    end
endmodule

// File: rtl/fetch_redirect_controller.sv
// Next-PC redirect arbitration with stall-time capture, plus the optional
// post-mispredict fetch-bubble sequencer and its saturating bubble counter.
module fetch_redirect_controller
    import MicroArchConf::*;
    import FetchUnitTypes::*;
#(
    parameter int STOP_ON_MISPRED = 0,
    parameter int PHASE_DELAY     = 2
)(
    input  logic                              clk,
    input  logic                              rstN,
    fetch_redirect_controller_if.slave        fetchBus
);
    localparam bit       STOP_EN    = (STOP_ON_MISPRED != 0);
    localparam bit [2:0] DELAY_LOAD = 3'(PHASE_DELAY - 1);

    RedirectEntry   pending;
    RedirectEntry   winner;
    logic [3:0]     reqValid;
    PC_Path         reqPC [4];
    logic           redirFire;

    FetchRedirPhase phase;
    FetchRedirPhase phaseNext;
    logic [2:0]     delayCnt;
    logic [2:0]     delayCntNext;
    logic           bubbleOn;
    logic [15:0]    bubbleCnt;

    assign reqValid = {fetchBus.predRedirValid, fetchBus.intrValid,
                       fetchBus.renRedirValid, fetchBus.cmtRedirValid};
    assign reqPC[0] = fetchBus.cmtRedirPC;
    assign reqPC[1] = fetchBus.renRedirPC;
    assign reqPC[2] = fetchBus.intrPC;
    assign reqPC[3] = fetchBus.predRedirPC;

    redirect_priority_select prioritySelect (
        .reqValid (reqValid),
        .reqPC    (reqPC),
        .pending  (pending),
        .winner   (winner)
    );

    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            pending <= REDIR_NONE;
        end else if (fetchBus.stall) begin
            pending <= winner;
        end else begin
            // Released (or superseded) on the first unstalled cycle.
            pending <= REDIR_NONE;
        end
    end

    assign redirFire             = rstN && !fetchBus.stall && winner.valid;
    assign fetchBus.redirValid   = redirFire;
    assign fetchBus.redirPC      = redirFire ? winner.pc : '0;
    assign fetchBus.redirSrc     = redirFire ? winner.src : 2'd0;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            phase    <= FETCH;
            delayCnt <= 3'd0;
        end else begin
            phase    <= phaseNext;
            delayCnt <= delayCntNext;
        end
    end

    always_comb begin
        phaseNext    = phase;
        delayCntNext = delayCnt;
        case (phase)
            FETCH: begin
                if (STOP_EN && fetchBus.mispredDetect) begin
                    if (DELAY_LOAD == 3'd0) begin
                        phaseNext = BUBBLE;
                    end else begin
                        phaseNext    = DELAY;
                        delayCntNext = DELAY_LOAD;
                    end
                end
            end
            DELAY: begin
                // Bubble starts PHASE_DELAY cycles after detection: leave once the count reaches zero.
                delayCntNext = delayCnt - 3'd1;
                if (delayCntNext == 3'd0) begin
                    phaseNext = BUBBLE;
                end
            end
            BUBBLE: phaseNext = BUBBLE;
            default: begin
                phaseNext    = FETCH;
                delayCntNext = 3'd0;
            end
        endcase
        if (fetchBus.cmtRedirValid) begin
            phaseNext    = FETCH;
            delayCntNext = 3'd0;
        end
    end

    assign bubbleOn            = rstN && (phase == BUBBLE) && !fetchBus.cmtRedirValid;
    assign fetchBus.sendBubble = bubbleOn;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            bubbleCnt <= 16'd0;
        end else if (bubbleOn && (bubbleCnt != 16'hFFFF)) begin
            bubbleCnt <= bubbleCnt + 16'd1;
        end
    end

    assign fetchBus.bubbleCycles = bubbleCnt;
endmodule

// File: tb/tb_fetch_redirect_controller.sv
// Directed and randomized checks of fetch_redirect_controller against a
// cycle-level behavioural model of redirect arbitration and bubble timing.
module tb_fetch_redirect_controller;
    import MicroArchConf::*;
    import FetchUnitTypes::*;

    localparam int PHASE_DELAY = 2;

    typedef struct packed {
        logic   cmtV;
        logic   renV;
        logic   intrV;
        logic   predV;
        logic   misp;
        logic   stall;
        PC_Path cmtPC;
        PC_Path renPC;
        PC_Path intrPC;
        PC_Path predPC;
    } Stim;

    typedef struct {
        bit     v;
        PC_Path pc;
        int     src;
    } Req;

    logic clk = 1'b0;
    logic rstN;
    Stim  nextIn;
    Stim  drv;

    Req   modelPend;
    int   bubbleWait;   // -1: fetching, >0: cycles left before bubbling, 0: bubbling
    int   modelBubbles;
    int   passCount = 0;
    int   checkCount = 0;

    always #5 clk = ~clk;

    fetch_redirect_controller_if bus ();
    fetch_redirect_controller_if bus0 ();

    assign bus.cmtRedirValid   = drv.cmtV;
    assign bus.cmtRedirPC      = drv.cmtPC;
    assign bus.renRedirValid   = drv.renV;
    assign bus.renRedirPC      = drv.renPC;
    assign bus.intrValid       = drv.intrV;
    assign bus.intrPC          = drv.intrPC;
    assign bus.predRedirValid  = drv.predV;
    assign bus.predRedirPC     = drv.predPC;
    assign bus.mispredDetect   = drv.misp;
    assign bus.stall           = drv.stall;

    assign bus0.cmtRedirValid  = drv.cmtV;
    assign bus0.cmtRedirPC     = drv.cmtPC;
    assign bus0.renRedirValid  = drv.renV;
    assign bus0.renRedirPC     = drv.renPC;
    assign bus0.intrValid      = drv.intrV;
    assign bus0.intrPC         = drv.intrPC;
    assign bus0.predRedirValid = drv.predV;
    assign bus0.predRedirPC    = drv.predPC;
    assign bus0.mispredDetect  = drv.misp;
    assign bus0.stall          = drv.stall;

    fetch_redirect_controller #(.STOP_ON_MISPRED(1), .PHASE_DELAY(PHASE_DELAY)) dut (
        .clk      (clk),
        .rstN     (rstN),
        .fetchBus (bus)
    );

    fetch_redirect_controller dutPlain (
        .clk      (clk),
        .rstN     (rstN),
        .fetchBus (bus0)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic Stim idleStim();
        Stim s;
        s = '0;
        return s;
    endfunction

    function automatic Stim randStim();
        Stim s;
        s        = '0;
        s.stall  = ($urandom_range(9) < 4);
        s.cmtV   = ($urandom_range(99) < 8);
        s.renV   = ($urandom_range(99) < 25);
        s.intrV  = ($urandom_range(99) < 20);
        s.predV  = ($urandom_range(99) < 35);
        s.misp   = ($urandom_range(99) < 15);
        s.cmtPC  = $urandom;
        s.renPC  = $urandom;
        s.intrPC = $urandom;
        s.predPC = $urandom;
        return s;
    endfunction

    // Oldest pending entry survives unless a live request strictly beats it,
    // or the live request is a commit redirect.
    function automatic Req pickWinner(input Stim s, input Req held);
        Req order [4];
        Req best;
        best     = '{v: 1'b0, pc: '0, src: 0};
        order[0] = '{v: s.cmtV,  pc: s.cmtPC,  src: 0};
        order[1] = '{v: s.renV,  pc: s.renPC,  src: 1};
        order[2] = '{v: s.intrV, pc: s.intrPC, src: 2};
        order[3] = '{v: s.predV, pc: s.predPC, src: 3};
        for (int i = 0; i < 4; i++) begin
            if (order[i].v) begin
                best = order[i];
                break;
            end
        end
        if (best.v && (!held.v || best.src < held.src || best.src == 0)) return best;
        return held;
    endfunction

    function automatic void resetModel();
        modelPend    = '{v: 1'b0, pc: '0, src: 0};
        bubbleWait   = -1;
        modelBubbles = 0;
    endfunction

    // One clock cycle: apply nextIn just after the edge, compare, then advance the model.
    task automatic runCycle(input bit doCheck);
        Req         w;
        logic       expValid;
        PC_Path     expPC;
        logic [1:0] expSrc;
        logic       expBubble;
        @(posedge clk);
        #1;
        drv = nextIn;
        #1;
        w         = pickWinner(drv, modelPend);
        expValid  = !drv.stall && w.v;
        expPC     = expValid ? w.pc : '0;
        expSrc    = expValid ? 2'(w.src) : 2'd0;
        expBubble = (bubbleWait == 0) && !drv.cmtV;
        if (doCheck) begin
            check("redirValid",        64'(bus.redirValid),    64'(expValid));
            check("redirPC",           64'(bus.redirPC),       64'(expPC));
            check("redirSrc",          64'(bus.redirSrc),      64'(expSrc));
            check("sendBubble",        64'(bus.sendBubble),    64'(expBubble));
            check("bubbleCycles",      64'(bus.bubbleCycles),  64'(modelBubbles));
            check("plain redirValid",  64'(bus0.redirValid),   64'(expValid));
            check("plain redirPC",     64'(bus0.redirPC),      64'(expPC));
            check("plain sendBubble",  64'(bus0.sendBubble),   64'd0);
            check("plain bubbleCycles", 64'(bus0.bubbleCycles), 64'd0);
        end
        if (drv.stall && w.v) modelPend = w;
        else modelPend = '{v: 1'b0, pc: '0, src: 0};
        if (expBubble && modelBubbles < 65535) modelBubbles++;
        if (drv.cmtV) bubbleWait = -1;
        else if (bubbleWait < 0 && drv.misp) bubbleWait = PHASE_DELAY - 1;
        else if (bubbleWait > 0) bubbleWait--;
    endtask

    task automatic checkResetOutputs(input string tag);
        check({tag, " redirValid"},   64'(bus.redirValid),   64'd0);
        check({tag, " redirPC"},      64'(bus.redirPC),      64'd0);
        check({tag, " redirSrc"},     64'(bus.redirSrc),     64'd0);
        check({tag, " sendBubble"},   64'(bus.sendBubble),   64'd0);
        check({tag, " bubbleCycles"}, 64'(bus.bubbleCycles), 64'd0);
    endtask

    function automatic Stim busyStim();
        Stim s;
        s        = '0;
        s.cmtV   = 1'b1;
        s.renV   = 1'b1;
        s.intrV  = 1'b1;
        s.predV  = 1'b1;
        s.misp   = 1'b1;
        s.cmtPC  = 32'h0000_9000;
        s.renPC  = 32'h0000_1000;
        s.intrPC = 32'h0000_0800;
        s.predPC = 32'h0000_2000;
        return s;
    endfunction

    initial begin
        int expB [8];
        int guard;
        expB = '{0, 0, 1, 1, 1, 0, 0, 0};

        // Reset: outputs held low while every input is active.
        rstN   = 1'b0;
        drv    = busyStim();
        nextIn = idleStim();
        resetModel();
        #2;
        checkResetOutputs("reset");
        #10;
        drv = idleStim();
        #11;
        rstN = 1'b1;

        // Mispredict pulse at cycle 0, commit redirect at cycle 5.
        for (int c = 0; c < 8; c++) begin
            nextIn = idleStim();
            if (c == 0) nextIn.misp = 1'b1;
            if (c == 5) begin
                nextIn.cmtV  = 1'b1;
                nextIn.cmtPC = 32'h0000_5000;
            end
            runCycle(1'b1);
            check($sformatf("bubble timing c%0d", c), 64'(bus.sendBubble), 64'(expB[c]));
        end
        check("bubble count after recovery", 64'(bus.bubbleCycles), 64'd3);

        // Mispredict coinciding with commit redirect never starts a bubble.
        nextIn       = idleStim();
        nextIn.misp  = 1'b1;
        nextIn.cmtV  = 1'b1;
        nextIn.cmtPC = 32'h0000_6000;
        runCycle(1'b1);
        for (int c = 0; c < 5; c++) begin
            nextIn = idleStim();
            runCycle(1'b1);
            check($sformatf("no bubble c%0d", c), 64'(bus.sendBubble), 64'd0);
        end

        // Zero-latency pass-through: ren beats pred.
        nextIn        = idleStim();
        nextIn.renV   = 1'b1;
        nextIn.renPC  = 32'h0000_1000;
        nextIn.predV  = 1'b1;
        nextIn.predPC = 32'h0000_2000;
        runCycle(1'b1);
        check("direct valid", 64'(bus.redirValid), 64'd1);
        check("direct pc",    64'(bus.redirPC),    64'h1000);
        check("direct src",   64'(bus.redirSrc),   64'd1);

        // Capture during stall: pred, then ren replaces it, later pred cannot.
        nextIn        = idleStim();
        nextIn.stall  = 1'b1;
        nextIn.predV  = 1'b1;
        nextIn.predPC = 32'h0000_2000;
        runCycle(1'b1);
        check("stall masks valid", 64'(bus.redirValid), 64'd0);
        nextIn        = idleStim();
        nextIn.stall  = 1'b1;
        nextIn.renV   = 1'b1;
        nextIn.renPC  = 32'h0000_1000;
        runCycle(1'b1);
        nextIn        = idleStim();
        nextIn.stall  = 1'b1;
        nextIn.predV  = 1'b1;
        nextIn.predPC = 32'h0000_3000;
        runCycle(1'b1);
        nextIn = idleStim();
        runCycle(1'b1);
        check("release valid", 64'(bus.redirValid), 64'd1);
        check("release pc",    64'(bus.redirPC),    64'h1000);
        check("release src",   64'(bus.redirSrc),   64'd1);
        nextIn = idleStim();
        runCycle(1'b1);
        check("released once", 64'(bus.redirValid), 64'd0);

        // Commit redirect on the unstall cycle beats a pending ren.
        nextIn       = idleStim();
        nextIn.stall = 1'b1;
        nextIn.renV  = 1'b1;
        nextIn.renPC = 32'h0000_1000;
        runCycle(1'b1);
        nextIn       = idleStim();
        nextIn.cmtV  = 1'b1;
        nextIn.cmtPC = 32'h0000_4000;
        runCycle(1'b1);
        check("cmt wins pc",  64'(bus.redirPC),  64'h4000);
        check("cmt wins src", 64'(bus.redirSrc), 64'd0);
        nextIn = idleStim();
        runCycle(1'b1);
        check("pending dropped", 64'(bus.redirValid), 64'd0);

        // Reset mid-stall with a pending interrupt redirect.
        nextIn        = idleStim();
        nextIn.stall  = 1'b1;
        nextIn.intrV  = 1'b1;
        nextIn.intrPC = 32'h0000_0800;
        runCycle(1'b1);
        nextIn = idleStim();
        @(posedge clk);
        #3;
        rstN = 1'b0;
        drv  = busyStim();
        #1;
        checkResetOutputs("mid-stall reset");
        drv = idleStim();
        #2;
        rstN = 1'b1;
        resetModel();
        for (int c = 0; c < 3; c++) begin
            nextIn = idleStim();
            runCycle(1'b1);
            check($sformatf("no redirect after reset c%0d", c), 64'(bus.redirValid), 64'd0);
        end

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            nextIn = randStim();
            runCycle(1'b1);
        end

        // Hold a bubble long enough to saturate the counter.
        nextIn      = idleStim();
        nextIn.misp = 1'b1;
        runCycle(1'b1);
        guard = 0;
        while (modelBubbles < 65535 && guard < 70000) begin
            nextIn = idleStim();
            runCycle(1'b0);
            guard++;
        end
        for (int c = 0; c < 3; c++) begin
            nextIn = idleStim();
            runCycle(1'b1);
        end
        check("bubble counter saturates", 64'(bus.bubbleCycles), 64'hFFFF);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule

// File: doc/fetch_redirect_controller.md
FETCH_REDIRECT_CONTROLLER -- requirements
Module: fetch_redirect_controller

Interface
REQ-001 SHALL have parameter STOP_ON_MISPRED, default 0: 1 enables the post-mispredict fetch-bubble FSM.
REQ-002 SHALL have parameter PHASE_DELAY, default 2, range 1..7: cycles from mispredict detection to bubble assertion.
REQ-003 SHALL have ports, clock and reset first:
  clk  in  1  clock.
  rstN  in  1  reset, asynchronous, active-low.
  cmtRedirValid  in  1  redirect from writeback/commit recovery.
  cmtRedirPC  in  PC_WIDTH  its target.
  renRedirValid  in  1  redirect from rename recovery.
  renRedirPC  in  PC_WIDTH  its target.
  intrValid  in  1  interrupt redirect.
  intrPC  in  PC_WIDTH  its target.
  predRedirValid  in  1  taken prediction from BTB, AXBTB, cyclic BTB or RAS.
  predRedirPC  in  PC_WIDTH  its target.
  mispredDetect  in  1  OR of valid mispredicted branch results.
  stall  in  1  next-PC stage stall.
  redirValid  out  1  redirect to the PC register this cycle.
  redirPC  out  PC_WIDTH  selected target.
  redirSrc  out  2  source: 0 cmt, 1 ren, 2 intr, 3 pred.
  sendBubble  out  1  request for a next-PC-stage bubble.
  bubbleCycles  out  16  saturating count of cycles with sendBubble high.

Function
REQ-004 SHALL apply fixed priority cmt > ren > intr > pred; a lower redirSrc code is a higher priority.
REQ-005 When stall=0 and no request is pending, SHALL drive redirValid/redirPC/redirSrc combinationally from the highest-priority valid input, with zero latency.
REQ-006 When stall=1, SHALL drive redirValid=0 and SHALL capture the highest-priority valid input into a pending register of valid, PC and source.
REQ-007 During stall, a new input SHALL replace the pending entry only if its priority is strictly higher; an equal-priority input SHALL overwrite only when its source is cmt.
REQ-008 On the first cycle with stall=0, SHALL output the higher-priority of the pending entry and the current inputs, and SHALL clear the pending entry at that clock edge.
REQ-009 When stall=0 and the inputs win over the pending entry, SHALL discard the pending entry, because a younger path is superseded.
REQ-010 A cmt redirect arriving in the same cycle that stall deasserts SHALL win over any pending entry.
REQ-011 The FSM SHALL have states FETCH, DELAY and BUBBLE; with STOP_ON_MISPRED=0 it SHALL remain in FETCH.
REQ-012 FETCH -> DELAY on mispredict SHALL occur when mispredDetect=1 and cmtRedirValid=0, loading a 3-bit counter with PHASE_DELAY-1.
REQ-013 DELAY SHALL decrement the counter each cycle and SHALL go to BUBBLE when the counter is 0.
REQ-014 BUBBLE SHALL hold sendBubble=1; sendBubble SHALL be 0 in FETCH and DELAY.
REQ-015 cmtRedirValid=1 SHALL force the next state to FETCH from any state and SHALL take precedence over a same-cycle mispredDetect.
REQ-016 sendBubble SHALL be masked to 0 combinationally in any cycle with cmtRedirValid=1.
REQ-017 mispredDetect in DELAY or BUBBLE SHALL be ignored and SHALL NOT restart the counter.
REQ-018 The FSM SHALL advance regardless of stall.
REQ-019 bubbleCycles SHALL increment on each cycle with sendBubble=1 and SHALL saturate at 0xFFFF.

Reset
REQ-020 On rstN=0, asynchronously: state FETCH, counter 0, pending entry invalid (PC 0, source 0), bubbleCycles 0.
REQ-021 During reset: redirValid=0, redirPC=0, redirSrc=0, sendBubble=0, independent of inputs.
REQ-022 Reset asserted mid-stall SHALL drop the pending redirect, and no redirect SHALL emerge after release.

Structure
REQ-023 RedirectSource enum (2-bit) and FetchRedirPhase enum SHALL live in FetchUnitTypes; PC_WIDTH and PC_Path SHALL come from the existing shared package.
REQ-024 The priority selector SHALL be a sub-module redirect_priority_select that picks the winner of 4 requests plus the pending entry, used both for capture and for output.

Verification
REQ-025 stall=0, renRedirValid=1 (PC 0x1000) with predRedirValid=1 (PC 0x2000) -> same cycle redirValid=1, redirPC=0x1000, redirSrc=1.
REQ-026 stall=1; cycle 1 pred 0x2000; cycle 2 ren 0x1000; cycle 3 pred 0x3000; cycle 4 stall=0 with no inputs -> redirPC=0x1000, src 1; cycle 5 redirValid=0.
REQ-027 Pending ren 0x1000 and cmt 0x4000 in the unstall cycle -> redirPC=0x4000, src 0; pending cleared.
REQ-028 STOP_ON_MISPRED=1, PHASE_DELAY=2, mispredDetect pulse at cycle 0 -> sendBubble=1 from cycle 2; cmt redirect at cycle 5 -> sendBubble=0 in cycle 5 and FETCH at cycle 6; bubbleCycles=3.
REQ-029 mispredDetect and cmtRedirValid in the same cycle -> state stays FETCH and sendBubble is never asserted.
REQ-030 rstN pulsed low during stall with a pending intr 0x800 -> all outputs 0; after release with stall=0 and no inputs -> redirValid stays 0.
